jtag_wb_bridge: RTL and testbench

//  Parametrised JTAG-to-Wishbone master, successor to the single-word JBUS bridge. A host drives

---
 rtl/jtag_wb_pkg.sv | 54 +++++
 rtl/jtag_cmd_sync.sv | 31 +++
 rtl/virtual_wire.sv | 19 +
 rtl/jtag_wb_bridge.sv | 189 ++++++++++++++++++
 tb/tb_jtag_wb_bridge.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_wb_pkg.sv
// Shared encodings and source/probe field layout for the JTAG-to-Wishbone bridge.
// Source word, MSB first: {seq, cmd, sel, cnt, adr, dat}. Probe word: {done_seq, status, busy, rdata}.
package jtag_wb_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_FILL  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_BUS_ERR = 2'b10,
    ST_BAD_CMD = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUS  = 2'b01,
    S_GAP  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic int src_adr_lsb(int dw);
    return dw;
  endfunction

  function automatic int src_cnt_lsb(int aw, int dw);
    return src_adr_lsb(dw) + aw;
  endfunction

  function automatic int src_sel_lsb(int cnt_w, int aw, int dw);
    return src_cnt_lsb(aw, dw) + cnt_w;
  endfunction

  function automatic int src_cmd_lsb(int cnt_w, int aw, int dw);
    return src_sel_lsb(cnt_w, aw, dw) + dw / 8;
  endfunction

  function automatic int src_seq_lsb(int cnt_w, int aw, int dw);
    return src_cmd_lsb(cnt_w, aw, dw) + 2;
  endfunction

  function automatic int src_width(int seq_w, int cnt_w, int aw, int dw);
    return src_seq_lsb(cnt_w, aw, dw) + seq_w;
  endfunction

  function automatic int prb_width(int seq_w, int dw);
    return dw + 3 + seq_w;
  endfunction

endpackage

// File: rtl/jtag_cmd_sync.sv
// Double-samples the JTAG source word and flags a new command once two samples
// agree (multi-bit skew guard) and its sequence tag differs from the last completed one.
module jtag_cmd_sync #(
  parameter int SRC_W = 82,
  parameter int SEQ_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [SRC_W-1:0] src_i,
  input  logic [SEQ_W-1:0] done_seq_i,
  output logic [SRC_W-1:0] cmd_o,
  output logic             new_o
);

  logic [SRC_W-1:0] s1_q;
  logic [SRC_W-1:0] s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= src_i;
      s2_q <= s1_q;
    end
  end

  assign cmd_o = s2_q;
  assign new_o = (s1_q == s2_q) && (s2_q[SRC_W-1 -: SEQ_W] != done_seq_i);

endmodule

// File: rtl/virtual_wire.sv
// Portable stand-in for the vendor JTAG source/probe macro: the JTAG side is
// flattened onto host_* ports so the bridge can be driven without the TAP.
module virtual_wire #(
  parameter int          SRC_W       = 1,
  parameter int          PRB_W       = 1,
  parameter logic [31:0] INSTANCE_ID = "JBUS"
) (
  input  logic [SRC_W-1:0] host_src_i,
  output logic [PRB_W-1:0] host_probe_o,
  output logic [31:0]      host_id_o,
  output logic [SRC_W-1:0] source_o,
  input  logic [PRB_W-1:0] probe_i
);

  assign source_o     = host_src_i;
  assign host_probe_o = probe_i;
  assign host_id_o    = INSTANCE_ID;

endmodule

// File: rtl/jtag_wb_bridge.sv
// JTAG-driven Wishbone master: executes READ, byte-selected WRITE and multi-word FILL
// commands and reports {done_seq, status, busy, rdata} back through the probe word.
module jtag_wb_bridge
  import jtag_wb_pkg::*;
#(
  parameter int          AW          = 32,
  parameter int          DW          = 32,
  parameter int          SEQ_W       = 4,
  parameter int          CNT_W       = 8,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] INSTANCE_ID = "JBUS",
  localparam int         SW          = DW / 8,
  localparam int         SRC_W       = src_width(SEQ_W, CNT_W, AW, DW),
  localparam int         PRB_W       = prb_width(SEQ_W, DW)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [SRC_W-1:0] host_src_i,
  output logic [PRB_W-1:0] host_probe_o,
  output logic [31:0]      host_id_o,
  output logic [1:0]       state_o,
  output logic [AW-1:0]    wb_adr_o,
  output logic [DW-1:0]    wb_dat_o,
  input  logic [DW-1:0]    wb_dat_i,
  output logic [SW-1:0]    wb_sel_o,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  output logic             wb_we_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  localparam int ADR_LSB = src_adr_lsb(DW);
  localparam int CNT_LSB = src_cnt_lsb(AW, DW);
  localparam int SEL_LSB = src_sel_lsb(CNT_W, AW, DW);
  localparam int CMD_LSB = src_cmd_lsb(CNT_W, AW, DW);
  localparam int SEQ_LSB = src_seq_lsb(CNT_W, AW, DW);
  localparam int WT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [SRC_W-1:0] source;
  logic [PRB_W-1:0] probe;
  logic [SRC_W-1:0] cmd_word;
  logic             cmd_new;

  state_e           state_q;
  cmd_e             cmd_q;
  status_e          res_q;
  status_e          status_q;
  logic [SEQ_W-1:0] seq_q;
  logic [SEQ_W-1:0] done_seq_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    adr_q;
  logic [DW-1:0]    dat_q;
  logic [SW-1:0]    sel_q;
  logic             we_q;
  logic             cyc_q;
  logic             busy_q;
  logic [DW-1:0]    rdata_q;
  logic [WT_W-1:0]  wait_q;

  logic [SEQ_W-1:0] f_seq;
  cmd_e             f_cmd;
  logic [SW-1:0]    f_sel;

  virtual_wire #(
    .SRC_W      (SRC_W),
    .PRB_W      (PRB_W),
    .INSTANCE_ID(INSTANCE_ID)
  ) u_vw (
    .host_src_i  (host_src_i),
    .host_probe_o(host_probe_o),
    .host_id_o   (host_id_o),
    .source_o    (source),
    .probe_i     (probe)
  );

  jtag_cmd_sync #(
    .SRC_W(SRC_W),
    .SEQ_W(SEQ_W)
  ) u_sync (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .src_i     (source),
    .done_seq_i(done_seq_q),
    .cmd_o     (cmd_word),
    .new_o     (cmd_new)
  );

  assign f_seq = cmd_word[SEQ_LSB +: SEQ_W];
  assign f_cmd = cmd_e'(cmd_word[CMD_LSB +: 2]);
  assign f_sel = cmd_word[SEL_LSB +: SW];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_NOP;
      res_q      <= ST_OK;
      status_q   <= ST_OK;
      seq_q      <= '0;
      done_seq_q <= '0;
      cnt_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      wait_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_new) begin
            seq_q   <= f_seq;
            cmd_q   <= f_cmd;
            cnt_q   <= cmd_word[CNT_LSB +: CNT_W];
            adr_q   <= cmd_word[ADR_LSB +: AW];
            dat_q   <= cmd_word[DW-1:0];
            sel_q   <= f_sel;
            busy_q  <= 1'b1;
            rdata_q <= '0;
            wait_q  <= '0;
            res_q   <= ST_OK;
            if (f_cmd == CMD_NOP) begin
              state_q <= S_DONE;
            end else if (f_cmd != CMD_READ && f_sel == '0) begin
              res_q   <= ST_BAD_CMD;
              state_q <= S_DONE;
            end else begin
              we_q    <= (f_cmd != CMD_READ);
              cyc_q   <= 1'b1;
              state_q <= S_BUS;
            end
          end
        end
        S_BUS: begin
          // err has priority over a simultaneous ack
          if (wb_err_i) begin
            cyc_q   <= 1'b0;
            res_q   <= ST_BUS_ERR;
            state_q <= S_DONE;
          end else if (wb_ack_i) begin
            cyc_q  <= 1'b0;
            wait_q <= '0;
            if (cmd_q == CMD_READ) begin
              rdata_q <= wb_dat_i;
            end else if (cmd_q == CMD_FILL) begin
              rdata_q <= rdata_q + DW'(1);
            end
            if (cmd_q == CMD_FILL && cnt_q != '0) begin
              cnt_q   <= cnt_q - CNT_W'(1);
              adr_q   <= adr_q + AW'(SW);
              state_q <= S_GAP;
            end else begin
              state_q <= S_DONE;
            end
          end else if (TIMEOUT != 0 && wait_q == WT_W'(TIMEOUT - 1)) begin
            cyc_q   <= 1'b0;
            res_q   <= ST_TIMEOUT;
            state_q <= S_DONE;
          end else begin
            wait_q <= wait_q + WT_W'(1);
          end
        end
        S_GAP: begin
          cyc_q   <= 1'b1;
          state_q <= S_BUS;
        end
        S_DONE: begin
          done_seq_q <= seq_q;
          status_q   <= res_q;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign probe    = {done_seq_q, status_q, busy_q, rdata_q};
  assign state_o  = state_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

endmodule

// File: tb/tb_jtag_wb_bridge.sv
// Directed bench for jtag_wb_bridge: expected bus beats and completions are queued by
// the stimulus and popped by independent bus/probe monitors.
module tb_jtag_wb_bridge;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SEQ_W   = 4;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;
  localparam int SW      = 4;
  localparam int SRC_W   = 82;
  localparam int PRB_W   = 39;

  localparam logic [1:0] C_NOP = 2'b00, C_READ = 2'b01, C_WRITE = 2'b10, C_FILL = 2'b11;
  localparam logic [1:0] R_OK = 2'b00, R_TMO = 2'b01, R_BERR = 2'b10, R_BAD = 2'b11;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic [SRC_W-1:0] host_src = '0;
  logic [PRB_W-1:0] host_probe;
  logic [31:0]      host_id;
  logic [1:0]       state;
  logic [AW-1:0]    wb_adr_o;
  logic [DW-1:0]    wb_dat_o;
  logic [DW-1:0]    wb_dat_i = '0;
  logic [SW-1:0]    wb_sel_o;
  logic             wb_stb_o;
  logic             wb_cyc_o;
  logic             wb_we_o;
  logic             wb_ack_i = 1'b0;
  logic             wb_err_i = 1'b0;

  jtag_wb_bridge #(
    .AW(AW), .DW(DW), .SEQ_W(SEQ_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .INSTANCE_ID("JBUS")
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .host_src_i  (host_src),
    .host_probe_o(host_probe),
    .host_id_o   (host_id),
    .state_o     (state),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_sel_o    (wb_sel_o),
    .wb_stb_o    (wb_stb_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_we_o     (wb_we_o),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // {we, sel, adr, dat}
  logic [68:0] exp_bus_q[$];
  // {check_rdata, seq, status, rdata}
  logic [38:0] exp_done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // slave model configuration (written only by the stimulus process)
  int          sl_waits    = 0;
  bit          sl_noack    = 1'b0;
  int          sl_err_beat = 0;
  logic [31:0] sl_rdata    = '0;
  int          sl_wcnt     = 0;
  int          sl_beat     = 0;

  always @(negedge sys_clk) begin
    if (!host_probe[32]) sl_beat = 0;
    if (sys_rst || !(wb_cyc_o && wb_stb_o)) begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      sl_wcnt  = 0;
    end else if (!wb_ack_i && !wb_err_i) begin
      if (!sl_noack && sl_wcnt == sl_waits) begin
        sl_beat++;
        if (sl_beat == sl_err_beat) wb_err_i = 1'b1;
        else wb_ack_i = 1'b1;
        wb_dat_i = sl_rdata;
      end else begin
        sl_wcnt++;
      end
    end
  end

  // bus monitor: one expected entry per rising cyc
  logic        prev_cyc = 1'b0;
  int          cyc_len  = 0;
  int          last_len = 0;
  logic [68:0] be;

  always @(negedge sys_clk) begin
    if (wb_cyc_o) begin
      if (!prev_cyc) begin
        if (exp_bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cycle actual_adr=%0h required=none", wb_adr_o);
        end else begin
          be = exp_bus_q.pop_front();
          check("beat_we", 64'(wb_we_o), 64'(be[68]));
          check("beat_sel", 64'(wb_sel_o), 64'(be[67:64]));
          check("beat_adr", 64'(wb_adr_o), 64'(be[63:32]));
          check("beat_stb", 64'(wb_stb_o), 64'(1));
          if (be[68]) check("beat_dat", 64'(wb_dat_o), 64'(be[31:0]));
        end
        cyc_len = 0;
      end
      cyc_len++;
    end else if (prev_cyc) begin
      last_len = cyc_len;
    end
    prev_cyc = wb_cyc_o;
  end

  // completion monitor: one expected entry per nonzero done_seq change
  logic [SEQ_W-1:0] prev_done = '0;
  logic [SEQ_W-1:0] cur_done;
  logic [38:0]      de;

  always @(negedge sys_clk) begin
    cur_done = host_probe[38:35];
    if (cur_done != prev_done && cur_done != '0) begin
      if (exp_done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual_seq=%0d required=none", cur_done);
      end else begin
        de = exp_done_q.pop_front();
        check("done_seq", 64'(cur_done), 64'(de[37:34]));
        check("done_status", 64'(host_probe[34:33]), 64'(de[33:32]));
        check("done_busy", 64'(host_probe[32]), 64'(0));
        if (de[38]) check("done_rdata", 64'(host_probe[31:0]), 64'(de[31:0]));
      end
    end
    prev_done = cur_done;
  end

  // driver tasks
  task automatic drive(input logic [3:0] seq, input logic [1:0] cmd, input logic [3:0] sel,
                       input logic [7:0] cnt, input logic [31:0] adr, input logic [31:0] dat);
    @(negedge sys_clk);
    host_src = {seq, cmd, sel, cnt, adr, dat};
  endtask

  task automatic slave_cfg(input int waits, input bit noack, input int err_beat,
                           input logic [31:0] rdata);
    sl_waits    = waits;
    sl_noack    = noack;
    sl_err_beat = err_beat;
    sl_rdata    = rdata;
  endtask

  task automatic wait_done(input logic [3:0] seq, input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge sys_clk);
      if (host_probe[38:35] == seq && !host_probe[32]) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_done actual_seq=%0d required_seq=%0d", host_probe[38:35], seq);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cyc"}, 64'(wb_cyc_o), 64'(0));
    check({tag, "_stb"}, 64'(wb_stb_o), 64'(0));
    check({tag, "_we"}, 64'(wb_we_o), 64'(0));
    check({tag, "_sel"}, 64'(wb_sel_o), 64'(0));
    check({tag, "_adr"}, 64'(wb_adr_o), 64'(0));
    check({tag, "_dat"}, 64'(wb_dat_o), 64'(0));
    check({tag, "_probe"}, 64'(host_probe), 64'(0));
    check({tag, "_state"}, 64'(state), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  int lat;

  initial begin
    repeat (3) @(negedge sys_clk);
    check_idle_outputs("reset");
    check("instance_id", 64'(host_id), 64'(32'h4A42_5553));
    sys_rst = 1'b0;

    // 1: single WRITE, also checks issue and completion latency
    slave_cfg(0, 1'b0, 0, 32'h0);
    exp_bus_q.push_back({1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF});
    exp_done_q.push_back({1'b0, 4'd1, R_OK, 32'h0});
    @(negedge sys_clk);
    host_src = {4'd1, C_WRITE, 4'hF, 8'd0, 32'h0000_0100, 32'hDEAD_BEEF};
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      if (wb_cyc_o) begin
        lat = k;
        break;
      end
    end
    check("issue_latency", 64'(lat), 64'(3));
    @(negedge sys_clk);
    check("done_not_early", 64'(host_probe[38:35]), 64'(0));
    @(negedge sys_clk);
    check("done_latency", 64'(host_probe[38:35]), 64'(1));
    wait_done(4'd1, 20);

    // 2: READ with three wait states
    slave_cfg(3, 1'b0, 0, 32'hDEAD_BEEF);
    exp_bus_q.push_back({1'b0, 4'hF, 32'h0000_0100, 32'h0});
    exp_done_q.push_back({1'b1, 4'd2, R_OK, 32'hDEAD_BEEF});
    drive(4'd2, C_READ, 4'hF, 8'd0, 32'h0000_0100, 32'h0);
    wait_done(4'd2, 50);

    // 3: FILL of four words wrapping the address space
    slave_cfg(0, 1'b0, 0, 32'h0);
    exp_bus_q.push_back({1'b1, 4'hF, 32'hFFFF_FFF8, 32'h55});
    exp_bus_q.push_back({1'b1, 4'hF, 32'hFFFF_FFFC, 32'h55});
    exp_bus_q.push_back({1'b1, 4'hF, 32'h0000_0000, 32'h55});
    exp_bus_q.push_back({1'b1, 4'hF, 32'h0000_0004, 32'h55});
    exp_done_q.push_back({1'b1, 4'd3, R_OK, 32'd4});
    drive(4'd3, C_FILL, 4'hF, 8'd3, 32'hFFFF_FFF8, 32'h55);
    wait_done(4'd3, 100);

    // 4: READ timing out against a silent slave
    slave_cfg(0, 1'b1, 0, 32'h0);
    exp_bus_q.push_back({1'b0, 4'hF, 32'h0000_0300, 32'h0});
    exp_done_q.push_back({1'b0, 4'd4, R_TMO, 32'h0});
    drive(4'd4, C_READ, 4'hF, 8'd0, 32'h0000_0300, 32'h0);
    wait_done(4'd4, 100);
    check("timeout_cyc_len", 64'(last_len), 64'(16));

    // 5: FILL aborted by a bus error on the third word
    slave_cfg(0, 1'b0, 3, 32'h0);
    exp_bus_q.push_back({1'b1, 4'h3, 32'h0000_0200, 32'hA5A5_A5A5});
    exp_bus_q.push_back({1'b1, 4'h3, 32'h0000_0204, 32'hA5A5_A5A5});
    exp_bus_q.push_back({1'b1, 4'h3, 32'h0000_0208, 32'hA5A5_A5A5});
    exp_done_q.push_back({1'b1, 4'd5, R_BERR, 32'd2});
    drive(4'd5, C_FILL, 4'h3, 8'd7, 32'h0000_0200, 32'hA5A5_A5A5);
    wait_done(4'd5, 100);

    // 6: unstable source, then reset during a bus wait and re-execution
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      host_src = (i % 2 == 0) ? {4'd6, C_READ, 4'hF, 8'd0, 32'h0000_0400, 32'h0}
                              : {4'd6, C_READ, 4'hF, 8'd0, 32'h0000_0404, 32'h0};
    end
    @(negedge sys_clk);
    check("unstable_cyc", 64'(wb_cyc_o), 64'(0));
    check("unstable_state", 64'(state), 64'(0));
    check("unstable_done_seq", 64'(host_probe[38:35]), 64'(5));
    slave_cfg(0, 1'b1, 0, 32'h0);
    exp_bus_q.push_back({1'b0, 4'hF, 32'h0000_0400, 32'h0});
    host_src = {4'd6, C_READ, 4'hF, 8'd0, 32'h0000_0400, 32'h0};
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge sys_clk);
      if (wb_cyc_o) begin
        lat = k;
        break;
      end
    end
    check("stable_issue_latency", 64'(lat), 64'(3));
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_idle_outputs("midrst");
    slave_cfg(0, 1'b0, 0, 32'h1234_5678);
    exp_bus_q.push_back({1'b0, 4'hF, 32'h0000_0400, 32'h0});
    exp_done_q.push_back({1'b1, 4'd6, R_OK, 32'h1234_5678});
    sys_rst = 1'b0;
    wait_done(4'd6, 50);

    // 7: WRITE with no byte selects is rejected without a bus cycle
    exp_done_q.push_back({1'b0, 4'd7, R_BAD, 32'h0});
    drive(4'd7, C_WRITE, 4'h0, 8'd0, 32'h0000_0500, 32'h1);
    wait_done(4'd7, 30);

    // 8: NOP completes without a bus cycle
    exp_done_q.push_back({1'b0, 4'd8, R_OK, 32'h0});
    drive(4'd8, C_NOP, 4'hF, 8'd0, 32'h0000_0600, 32'h2);
    wait_done(4'd8, 30);

    // 9: same seq re-presented with a different payload must not run
    drive(4'd8, C_WRITE, 4'hF, 8'd0, 32'h0000_0700, 32'h3);
    repeat (20) @(negedge sys_clk);
    check("same_seq_state", 64'(state), 64'(0));
    check("same_seq_done", 64'(host_probe[38:35]), 64'(8));

    repeat (5) @(negedge sys_clk);
    check("bus_queue_empty", 64'(exp_bus_q.size()), 64'(0));
    check("done_queue_empty", 64'(exp_done_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
